// File: rtl/cajero_param_if.sv
// Handshake and readback bundle for the parametrised cash-dispenser decomposer.
// The master side drives the command and select; the slave side reports status, counts and remainder.
interface cajero_param_if #(
  parameter int W  = 9,
  parameter int CW = 9,
  parameter int SW = 2
) ();
  logic          start;
  logic          pause;
  logic [W-1:0]  X;
  logic [SW-1:0] S;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] F;
  logic [W-1:0]  R;

  modport master (output start, pause, X, S, input busy, done, err, F, R);
  modport slave  (input start, pause, X, S, output busy, done, err, F, R);
endinterface

// File: rtl/cajero_param.sv
// Greedy decomposition of an amount into N descending denominations, one subtraction per clock,
// with a per-denomination cap, pause, and per-denomination count readback.
module cajero_param #(
  parameter int             W      = 9,
  parameter int             N      = 4,
  parameter int             CW     = 9,
  parameter logic [N*W-1:0] DENOMS = {9'd5, 9'd10, 9'd20, 9'd50},
  parameter int             MAXC   = 511,
  parameter int             SW     = 2
) (
  input logic           clk,
  input logic           rst,
  cajero_param_if.slave bus
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CAP  = CW'(MAXC);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt [N];
  logic [IW-1:0] idx;
  logic          errq;
  logic [W-1:0]  denom;
  logic [CW-1:0] curCnt;
  logic          load, sub, adv, finish;

  // Denomination and count addressed by the current index
  always_comb begin
    denom  = '0;
    curCnt = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        denom  = DENOMS[i*W +: W];
        curCnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // One action per RUN cycle: subtract if allowed, otherwise move to the next denomination, otherwise finish
  always_comb begin
    next   = state;
    load   = 1'b0;
    sub    = 1'b0;
    adv    = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.pause) begin
          load = 1'b1;
          next = RUN;
        end
      end
      RUN: begin
        if (!bus.pause) begin
          if (rem >= denom && curCnt < CAP) begin
            sub = 1'b1;
          end else if (idx < LAST) begin
            adv = 1'b1;
          end else begin
            finish = 1'b1;
            next   = DONE;
          end
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // err is latched on the way into DONE so it is already valid during the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      idx  <= '0;
      errq <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (load) begin
      rem  <= bus.X;
      idx  <= '0;
      errq <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (sub) begin
      rem <= rem - denom;
      for (int i = 0; i < N; i++) begin
        if (idx == IW'(i)) cnt[i] <= curCnt + CW'(1);
      end
    end else if (adv) begin
      idx <= idx + IW'(1);
    end else if (finish) begin
      errq <= (rem != '0);
    end
  end

  always_comb begin
    bus.F = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.S == SW'(i)) bus.F = cnt[i];
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.err  = errq;
  assign bus.R    = rem;

endmodule

// File: tb/tb_cajero_param.sv
// Self-checking bench: two instances (default cap; cap 7 with a 3-bit select) share stimulus and are
// compared against a greedy reference model and a table of hand-derived vectors.
module tb_cajero_param;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic [8:0] X;
  logic [2:0] sel;

  int checks = 0;
  int errors = 0;

  cajero_param_if #(.W(9), .CW(9), .SW(2)) bA ();
  cajero_param_if #(.W(9), .CW(9), .SW(3)) bB ();

  assign bA.start = start;
  assign bA.pause = pause;
  assign bA.X     = X;
  assign bA.S     = sel[1:0];
  assign bB.start = start;
  assign bB.pause = pause;
  assign bB.X     = X;
  assign bB.S     = sel;

  cajero_param dutA (.clk(clk), .rst(rst), .bus(bA));
  cajero_param #(.MAXC(7), .SW(3)) dutB (.clk(clk), .rst(rst), .bus(bB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              x;
    int              pauseAt;
    int              pauseLen;
    int              restartAt;
    int              busyA;
    int              busyB;
    logic [3:0][8:0] cA;
    logic [3:0][8:0] cB;
    int              rA;
    int              rB;
    int              eA;
    int              eB;
  } vec_t;

  function automatic logic [3:0][8:0] pk(input int a, input int b, input int c, input int d);
    logic [3:0][8:0] v;
    v[0] = 9'(a);
    v[1] = 9'(b);
    v[2] = 9'(c);
    v[3] = 9'(d);
    return v;
  endfunction

  // Reference: greedy over {50,20,10,5} with a per-denomination cap; RUN length is subtractions plus N
  function automatic void model(input int x, input int maxc, output logic [3:0][8:0] c,
                                output int rem, output int cycles);
    int den [4] = '{50, 20, 10, 5};
    int k;
    rem    = x;
    cycles = 4;
    for (int i = 0; i < 4; i++) begin
      k = rem / den[i];
      if (k > maxc) k = maxc;
      rem    = rem - k * den[i];
      cycles = cycles + k;
      c[i]   = 9'(k);
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int pauseAt, input int pauseLen, input int restartAt,
                               output int nA, output int nB, output int eA, output int eB);
    bit         dA, dB;
    int         pLeft;
    logic [8:0] prevR;
    nA = 0; nB = 0; eA = -1; eB = -1; dA = 0; dB = 0; pLeft = 0; prevR = '0;
    @(negedge clk);
    X = 9'(x); start = 1'b1; pause = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyRiseA", int'(bA.busy), 1);
    checkOutput("busyRiseB", int'(bB.busy), 1);
    for (int cyc = 0; cyc < 1000 && !(dA && dB); cyc++) begin
      if (pause) checkOutput("pauseHoldR", int'(bA.R), int'(prevR));
      prevR = bA.R;
      if (bA.busy) nA++;
      if (bB.busy) nB++;
      if (bA.done) begin
        dA = 1;
        eA = int'(bA.err);
        checkOutput("busyLowAtDoneA", int'(bA.busy), 0);
      end
      if (bB.done) begin
        dB = 1;
        eB = int'(bB.err);
      end
      start = 1'b0;
      if (restartAt >= 0 && nA == restartAt && bA.busy) begin
        start = 1'b1;
        X     = 9'd100;
      end
      if (pauseAt >= 0 && nA == pauseAt && bA.busy) pLeft = pauseLen;
      if (pLeft > 0) begin
        pause = 1'b1;
        pLeft--;
      end else begin
        pause = 1'b0;
      end
      if (!(dA && dB)) @(negedge clk);
    end
    pause = 1'b0;
    start = 1'b0;
    if (!(dA && dB)) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: done seen A=%0d B=%0d, expected both 1", dA, dB);
    end
    @(negedge clk);
    checkOutput("donePulseA", int'(bA.done), 0);
    checkOutput("donePulseB", int'(bB.done), 0);
  endtask

  task automatic runAndCheck(input string tag, input vec_t v);
    int nA, nB, eA, eB;
    applyStimulus(v.x, v.pauseAt, v.pauseLen, v.restartAt, nA, nB, eA, eB);
    checkOutput({tag, ".busyA"}, nA, v.busyA);
    checkOutput({tag, ".busyB"}, nB, v.busyB);
    checkOutput({tag, ".errDoneA"}, eA, v.eA);
    checkOutput({tag, ".errDoneB"}, eB, v.eB);
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      #1;
      checkOutput($sformatf("%s.FA[%0d]", tag, i), int'(bA.F), int'(v.cA[i]));
      checkOutput($sformatf("%s.FB[%0d]", tag, i), int'(bB.F), int'(v.cB[i]));
    end
    sel = 3'd0;
    checkOutput({tag, ".RA"}, int'(bA.R), v.rA);
    checkOutput({tag, ".RB"}, int'(bB.R), v.rB);
    checkOutput({tag, ".errHeldA"}, int'(bA.err), v.eA);
    checkOutput({tag, ".errHeldB"}, int'(bB.err), v.eB);
  endtask

  vec_t tbl [5];
  vec_t rv;

  initial begin
    tbl[0] = '{185, -1, 0, -1, 10, 10, pk(3,1,1,1),  pk(3,1,1,1), 0, 0, 0, 0};
    tbl[1] = '{7,   -1, 0, -1, 5,  5,  pk(0,0,0,1),  pk(0,0,0,1), 2, 2, 1, 1};
    tbl[2] = '{500, -1, 0, -1, 14, 19, pk(10,0,0,0), pk(7,7,1,0), 0, 0, 0, 0};
    tbl[3] = '{185,  4, 3, -1, 13, 13, pk(3,1,1,1),  pk(3,1,1,1), 0, 0, 0, 0};
    tbl[4] = '{185, -1, 0,  4, 10, 10, pk(3,1,1,1),  pk(3,1,1,1), 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; pause = 1'b0; X = '0; sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rstBusy", int'(bA.busy), 0);
    checkOutput("rstDone", int'(bA.done), 0);
    checkOutput("rstErr", int'(bA.err), 0);
    checkOutput("rstR", int'(bA.R), 0);
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      #1;
      checkOutput($sformatf("rstF[%0d]", i), int'(bA.F), 0);
    end
    sel = '0;

    for (int t = 0; t < 5; t++) runAndCheck($sformatf("vec%0d", t), tbl[t]);

    for (int s = 4; s < 8; s++) begin
      sel = 3'(s);
      #1;
      checkOutput($sformatf("selOutOfRange[%0d]", s), int'(bB.F), 0);
    end
    sel = '0;

    for (int r = 0; r < 15; r++) begin
      rv.x = int'($urandom_range(0, 511));
      rv.pauseAt = -1; rv.pauseLen = 0; rv.restartAt = -1;
      model(rv.x, 511, rv.cA, rv.rA, rv.busyA);
      model(rv.x, 7,   rv.cB, rv.rB, rv.busyB);
      rv.eA = (rv.rA != 0) ? 1 : 0;
      rv.eB = (rv.rB != 0) ? 1 : 0;
      runAndCheck($sformatf("rnd%0d_x%0d", r, rv.x), rv);
    end

    // Reset landing in the 4th RUN cycle of a 185 run
    @(negedge clk);
    X = 9'd185; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstBusy", int'(bA.busy), 0);
    checkOutput("midRstR", int'(bA.R), 0);
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      #1;
      checkOutput($sformatf("midRstF[%0d]", i), int'(bA.F), 0);
    end
    sel = '0;
    rv = '{0, -1, 0, -1, 4, 4, pk(0,0,0,0), pk(0,0,0,0), 0, 0, 0, 0};
    runAndCheck("zero", rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cajero_param.md
Name: cajero_param

Overview:
Parametrised successor to the fixed four-denomination cash-dispenser datapath/FSM pair. It takes an amount X and decomposes it greedily into N configurable denominations, largest first, at one subtraction per clock. It supports pause and a per-denomination dispense cap, and flags amounts that cannot be fully paid. Per-denomination counts are read back through a select port, and the block drops into the top level in place of the current datapath + FSM + deco trio.

Parameters:
W, 9, amount/remainder width in bits
N, 4, number of denominations (N >= 1)
CW, 9, width of each per-denomination count
DENOMS, {9'd5,9'd10,9'd20,9'd50}, packed N*W bits; entry i at [i*W +: W]; entry 0 is the largest; strictly descending, all nonzero
MAXC, 511, max units dispensed per denomination per run (MAXC <= 2^CW-1)
SW, 2, select width (2^SW >= N)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin decomposition of X; sampled only in IDLE
pause  input  1  freezes all internal state while high
X  input  W  amount to decompose, captured on accepted start
S  input  SW  denomination select for F
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run completes
err  output  1  remainder nonzero at completion; held until next accepted start
F  output  CW  count of denomination S from the last/current run
R  output  W  current remainder register

Behaviour:
- Reset (rst high at a clock edge, in any state, mid-run included): state=IDLE, all counts=0, R=0, idx=0, busy=0, done=0, err=0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 and pause=0, then R<=X, all counts<=0, idx<=0, err<=0, go to RUN. busy rises in the cycle after start is sampled. start while pause=1 is ignored.
- RUN, pause=0, one action per cycle, evaluated in this priority:
  - If R >= DENOMS[idx] and count[idx] < MAXC: R<=R-DENOMS[idx] and count[idx]<=count[idx]+1.
  - Else if idx < N-1: idx<=idx+1.
  - Else: go to DONE.
- RUN length = (total subtractions) + N cycles.
- DONE: busy=0, done=1 for exactly this cycle, err=(R!=0); next state IDLE (pause ignored in DONE).
- pause=1 in RUN: R, counts, idx and state all hold; busy stays 1.
- start while busy or in DONE: ignored, with no restart.
- Counts, R and err hold after completion until the next accepted start or reset.
- F = count[S], combinational from the registered counts. When S >= N, F=0.
- Arithmetic: comparison and subtraction are unsigned at W bits. R never underflows because subtraction only happens when R >= denom.
- X=0: no subtractions; RUN lasts N cycles, then done with err=0.

Test Plan:
- Reset, then X=185, start 1 cycle -> busy high for 10 cycles; done pulses; F for S=0..3 = 3,1,1,1; R=0; err=0.
- X=7 -> counts 0,0,0,1; R=2; err=1 after done; busy high for 5 cycles.
- MAXC=7, X=500 -> counts 7,7,1,0; R=0; err=0; busy high for 19 cycles.
- X=185 with pause held 3 cycles mid-run -> same final counts; busy high for 13 cycles; no state change while paused.
- rst asserted in the 4th RUN cycle of X=185 -> next cycle busy=0, all F=0, R=0. A new start with X=0 then gives busy for 4 cycles, done, err=0.
- start re-pulsed with X=100 during a run of X=185 -> ignored; results match 185. S=3'b... out of range (N=4, SW=3 build) -> F=0.
